uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-002 Parameter BAUD_DIV, default 651: sysclk cycles per oversample tick (100 MHz, 9600 baud, 16x).
REQ-003 Parameter FIFO_DEPTH, default 4: receive FIFO entries, power of two, 2..64.
REQ-004 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity; used only when parity is compiled in.
REQ-005 sysclk  in  1  system clock; all state on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 UART_RX  in  1  serial line, idle high, asynchronous to sysclk.
REQ-008 rx_data  out  DATA_BITS  FIFO head word, LSB = first received bit.
REQ-009 rx_valid  out  1  FIFO not empty; rx_data is valid.
REQ-010 rx_ready  in  1  consumer accepts head when rx_valid && rx_ready.
REQ-011 frame_err  out  1  one-cycle pulse: stop bit sampled low.
REQ-012 parity_err  out  1  one-cycle pulse: parity mismatch (tied 0 when parity is compiled out).
REQ-013 overrun  out  1  one-cycle pulse: good frame dropped because the FIFO was full.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored words.

Function
REQ-015 UART_RX SHALL pass through a 2-FF synchronizer; both stages take reset value 1.
REQ-016 The tick counter SHALL count 0..BAUD_DIV-1 and emit a 1-cycle tick at wrap; it runs free.
REQ-017 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; a sample counter 0..15 advances on each tick.
REQ-018 IDLE: on a synchronized low, clear the sample counter and enter START.
REQ-019 START: at sample 8, a vote of high SHALL return the FSM to IDLE (glitch reject), with no error and no write; a vote of low SHALL continue; at sample 15, enter DATA.
REQ-020 Each bit value SHALL be the majority of the synchronized line at samples 7, 8 and 9.
REQ-021 DATA: shift in DATA_BITS bits LSB first, one per 16 ticks; then enter PARITY if compiled in, otherwise STOP.
REQ-022 STOP: at sample 9, decide the frame and return to IDLE immediately (half-bit early for resync).
REQ-023 Stop bit low SHALL pulse frame_err and discard the word; frame_err takes priority over parity_err.
REQ-024 Good frame with FIFO not full SHALL be written the cycle after the STOP decision; rx_valid is high on the following cycle.
REQ-025 Good frame with FIFO full and no pop in the same cycle SHALL pulse overrun and drop the new word; stored words are unchanged.
REQ-026 FIFO full with a pop in the same cycle as a write SHALL accept both; fifo_count is unchanged.
REQ-027 The FIFO SHALL be first-word-fall-through; a pop advances the head on the next edge, and pointers wrap modulo FIFO_DEPTH.
REQ-028 rx_ready while FIFO empty SHALL have no effect; fifo_count never underflows.

Reset
REQ-029 Asserting reset SHALL asynchronously force: FSM to IDLE; all counters and FIFO pointers to 0; rx_valid, frame_err, parity_err and overrun to 0; fifo_count to 0; rx_data to 0.
REQ-030 A reset mid-frame SHALL abandon the frame; after release, the next falling edge starts a new frame.

Configuration
REQ-031 With macro UART_RX_PARITY_EN defined, the PARITY state SHALL sample one bit after the data bits and check it against PARITY_ODD; a mismatch pulses parity_err and discards the word.
REQ-032 Without UART_RX_PARITY_EN, the PARITY state and its checker SHALL be absent, and parity_err SHALL be constant 0.

Verification
REQ-033 Default parameters, send 0x55 (8N1), rx_ready=0 -> rx_valid=1, rx_data=0x55, fifo_count=1, no error pulses.
REQ-034 Low glitch of 4000 ns on an idle line -> FSM returns to IDLE, fifo_count stays 0, no pulses.
REQ-035 Frame 0xA3 with stop bit forced low -> one frame_err pulse, fifo_count unchanged, next frame 0x3C is received correctly.
REQ-036 FIFO_DEPTH=4, send 5 frames 0x01..0x05 with rx_ready=0 -> overrun pulses once, then pops return 0x01..0x04.
REQ-037 UART_RX_PARITY_EN defined, even parity: 0x07 with parity bit 1 -> stored; 0x07 with parity bit 0 -> parity_err pulse, not stored.
REQ-038 Assert reset during the 4th data bit of a frame -> all outputs 0 at once; after release, frame 0xC4 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver feeding a first-word-fall-through receive FIFO.
// Optional parity checking is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 651,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          UART_RX,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TICK_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(BAUD_DIV - 1);
  localparam logic [2:0]        LAST_BIT   = 3'(DATA_BITS - 1);
  localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_fifo: DATA_BITS must be 5..8");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: FIFO_DEPTH must be a power of two in 2..64");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_rx_fifo: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_next;
  logic                  rx_meta, rx_sync;
  logic [TICK_W-1:0]     tick_cnt;
  logic                  tick;
  logic [3:0]            sample_cnt;
  logic [2:0]            bit_cnt;
  logic [1:0]            hist;
  logic                  vote;
  logic [DATA_BITS-1:0]  shift_reg;
  logic                  take_bit;
  logic                  decide;
  logic                  good_frame;
  logic                  wr_pending;
  logic [DATA_BITS-1:0]  wr_word;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
  logic                  full, push, pop;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  // hist holds the two previous oversamples, so at sample N the vote covers N-2, N-1 and N
  assign vote = (hist[1] & hist[0]) | (hist[1] & rx_sync) | (hist[0] & rx_sync);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_next;
  end

`ifdef UART_RX_PARITY_EN
  logic take_par;
  logic par_bit;
  logic par_fail;
`endif

  always_comb begin
    state_next = state;
    take_bit   = 1'b0;
    decide     = 1'b0;
`ifdef UART_RX_PARITY_EN
    take_par   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_sync) state_next = START;
      end
      START: begin
        if (tick) begin
          if (sample_cnt == 4'd8 && vote) state_next = IDLE;
          else if (sample_cnt == 4'd15) state_next = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (sample_cnt == 4'd9) take_bit = 1'b1;
          if (sample_cnt == 4'd15 && bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (sample_cnt == 4'd9) take_par = 1'b1;
          if (sample_cnt == 4'd15) state_next = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack to catch the next start edge
        if (tick && sample_cnt == 4'd9) begin
          decide     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      hist       <= 2'b11;
      shift_reg  <= '0;
    end else begin
      if (state == IDLE) sample_cnt <= '0;
      else if (tick) sample_cnt <= sample_cnt + 1'b1;
      if (state != DATA) bit_cnt <= '0;
      else if (tick && sample_cnt == 4'd15) bit_cnt <= bit_cnt + 1'b1;
      if (tick) hist <= {hist[0], rx_sync};
      if (take_bit) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_fail = ((^shift_reg) ^ par_bit) != 1'(PARITY_ODD);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (take_par) par_bit <= vote;
      parity_err <= decide && vote && par_fail;
    end
  end

  assign good_frame = decide && vote && !par_fail;
`else
  assign parity_err = 1'b0;
  assign good_frame = decide && vote;
`endif

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      frame_err  <= 1'b0;
      wr_pending <= 1'b0;
      wr_word    <= '0;
    end else begin
      frame_err  <= decide && !vote;
      wr_pending <= good_frame;
      if (good_frame) wr_word <= shift_reg;
    end
  end

  // A full FIFO still accepts a write when the head is popped in the same cycle
  assign full     = (count == FULL_COUNT);
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  assign push     = wr_pending && (!full || pop);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overrun <= wr_pending && full && !pop;
    end
  end

  always_ff @(posedge sysclk) begin
    if (push) mem[wr_ptr] <= wr_word;
  end

  assign rx_data    = rx_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into uart_rx_fifo; popped words are checked by a scoreboard monitor.
// Define UART_RX_PARITY_EN for both files to exercise the parity checker.
module tb_uart_rx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int BAUD_DIV   = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int BIT_NS     = 16 * BAUD_DIV * 10;

  logic                 sysclk;
  logic                 reset;
  logic                 uart_rx;
  logic                 rx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 overrun;
  logic [2:0]           fifo_count;

  int checks  = 0;
  int errors  = 0;
  int fe_seen = 0;
  int pe_seen = 0;
  int ov_seen = 0;
  logic [7:0] exp_q[$];
  logic [7:0] sb_want;

  uart_rx_fifo #(
    .DATA_BITS (DATA_BITS),
    .BAUD_DIV  (BAUD_DIV),
    .FIFO_DEPTH(FIFO_DEPTH),
    .PARITY_ODD(0)
  ) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .UART_RX   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun),
    .fifo_count(fifo_count)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic even_par(input logic [7:0] d);
    return ^d;
  endfunction

  // Drives one frame on the line; the parity bit only goes out when parity is compiled in
  task automatic applyStimulus(input logic [7:0] data, input logic par, input logic stop);
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < DATA_BITS; i++) begin
      uart_rx = data[i];
      #(BIT_NS);
    end
`ifdef UART_RX_PARITY_EN
    uart_rx = par;
    #(BIT_NS);
`else
    if (par === 1'bx) $display("[TB] note: unknown parity argument");
`endif
    uart_rx = stop;
    #(BIT_NS);
    uart_rx = 1'b1;
  endtask

  task automatic drainFifo(input string name);
    rx_ready = 1'b1;
    for (int i = 0; i < 200 && fifo_count != 0; i++) begin
      @(posedge sysclk);
      #1;
    end
    checkOutput(name, {29'b0, fifo_count}, 32'd0);
    rx_ready = 1'b0;
  endtask

  // Scoreboard monitor: every accepted head word is compared against the oldest expected word
  always @(negedge sysclk) begin
    if (reset) begin
      if (frame_err) fe_seen++;
      if (parity_err) pe_seen++;
      if (overrun) ov_seen++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop: got 0x%0h, expected no word", rx_data);
        end else begin
          sb_want = exp_q.pop_front();
          checkOutput("pop_data", {24'b0, rx_data}, {24'b0, sb_want});
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    uart_rx  = 1'b1;
    rx_ready = 1'b0;
    reset    = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(posedge sysclk);
    #1;
    checkOutput("rst_rx_valid",   {31'b0, rx_valid},   32'd0);
    checkOutput("rst_rx_data",    {24'b0, rx_data},    32'd0);
    checkOutput("rst_fifo_count", {29'b0, fifo_count}, 32'd0);
    checkOutput("rst_pulses",     {29'b0, frame_err, parity_err, overrun}, 32'd0);
    reset = 1'b1;
    #(BIT_NS);

    exp_q.push_back(8'h55);
    applyStimulus(8'h55, even_par(8'h55), 1'b1);
    checkOutput("f55_rx_valid",   {31'b0, rx_valid},   32'd1);
    checkOutput("f55_rx_data",    {24'b0, rx_data},    32'h55);
    checkOutput("f55_fifo_count", {29'b0, fifo_count}, 32'd1);
    checkOutput("f55_no_pulses",  fe_seen + pe_seen + ov_seen, 32'd0);
    drainFifo("f55_drain");

    rx_ready = 1'b1;
    repeat (5) @(posedge sysclk);
    #1;
    checkOutput("empty_pop_count", {29'b0, fifo_count}, 32'd0);
    checkOutput("empty_pop_valid", {31'b0, rx_valid},   32'd0);
    rx_ready = 1'b0;

    uart_rx = 1'b0;
    #80;
    uart_rx = 1'b1;
    #(2 * BIT_NS);
    checkOutput("glitch_count",  {29'b0, fifo_count}, 32'd0);
    checkOutput("glitch_pulses", fe_seen + pe_seen + ov_seen, 32'd0);

    applyStimulus(8'hA3, even_par(8'hA3), 1'b0);
    #(BIT_NS);
    checkOutput("ferr_pulses", fe_seen,  32'd1);
    checkOutput("ferr_no_perr", pe_seen, 32'd0);
    checkOutput("ferr_count", {29'b0, fifo_count}, 32'd0);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, even_par(8'h3C), 1'b1);
    checkOutput("f3c_count", {29'b0, fifo_count}, 32'd1);
    drainFifo("f3c_drain");

    for (int i = 1; i <= 5; i++) begin
      d = 8'(i);
      if (i <= FIFO_DEPTH) exp_q.push_back(d);
      applyStimulus(d, even_par(d), 1'b1);
    end
    checkOutput("ovr_pulses", ov_seen, 32'd1);
    checkOutput("ovr_count", {29'b0, fifo_count}, 32'd4);
    checkOutput("ovr_head", {24'b0, rx_data}, 32'h01);
    drainFifo("ovr_drain");

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h07);
    applyStimulus(8'h07, 1'b1, 1'b1);
    checkOutput("par_ok_count", {29'b0, fifo_count}, 32'd1);
    checkOutput("par_ok_no_err", pe_seen, 32'd0);
    applyStimulus(8'h07, 1'b0, 1'b1);
    checkOutput("par_bad_err", pe_seen, 32'd1);
    checkOutput("par_bad_count", {29'b0, fifo_count}, 32'd1);
    drainFifo("par_drain");
`endif

    applyStimulus(8'h99, even_par(8'h99), 1'b1);
    checkOutput("pre_rst_valid", {31'b0, rx_valid}, 32'd1);
    d = 8'h5A;
    uart_rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 3; i++) begin
      uart_rx = d[i];
      #(BIT_NS);
    end
    uart_rx = d[3];
    #(BIT_NS / 2);
    reset = 1'b0;
    #1;
    checkOutput("midrst_rx_valid",   {31'b0, rx_valid},   32'd0);
    checkOutput("midrst_rx_data",    {24'b0, rx_data},    32'd0);
    checkOutput("midrst_fifo_count", {29'b0, fifo_count}, 32'd0);
    checkOutput("midrst_pulses",     {29'b0, frame_err, parity_err, overrun}, 32'd0);
    uart_rx = 1'b1;
    #(2 * BIT_NS - 1);
    reset = 1'b1;
    #(BIT_NS);
    exp_q.push_back(8'hC4);
    applyStimulus(8'hC4, even_par(8'hC4), 1'b1);
    checkOutput("fc4_count", {29'b0, fifo_count}, 32'd1);
    checkOutput("fc4_data",  {24'b0, rx_data},    32'hC4);
    drainFifo("fc4_drain");

    checkOutput("total_frame_err", fe_seen, 32'd1);
`ifdef UART_RX_PARITY_EN
    checkOutput("total_parity_err", pe_seen, 32'd1);
`else
    checkOutput("total_parity_err", pe_seen, 32'd0);
`endif
    checkOutput("total_overrun", ov_seen, 32'd1);
    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
